bnn_neuron_feeder: RTL and testbench
====================================

# bnn_neuron_feeder

Frame sequencer that drives one binary neuron. It buffers a frame of DEPTH activation bytes and DEPTH weight bytes, written over a byte-wide load port. On a start pulse it clears the neuron, streams the (activation, weight) pairs one per cycle, waits out the neuron pipeline, then captures the neuron's 1-bit sign output as the frame result. It sits between the host/load logic and the neuron's input_data/weight/ena side.

## Interface
- DEPTH, default 8: pairs per frame, range 2–16.
- NRN_LAT, default 2: cycles from the last pair presented to a stable neuron output.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-high reset. The name follows the codebase; 1 means reset.
- ena  in  1  global enable. When 0, the FSM, counters and loads hold, and nrn_ena is forced 0.
- ld_valid  in  1  load request.
- ld_sel  in  1  load target: 0 = activation buffer, 1 = weight buffer.
- ld_data  in  8  load byte.
- ld_ready  out  1  load accepted when ld_valid & ld_ready at an edge.
- wclr  in  1  clears the weight count (weights are otherwise kept across frames).
- start  in  1  frame start, sampled in IDLE only.
- o_neuron  in  1  neuron sign output.
- nrn_rst  out  1  neuron accumulator clear, active-high.
- nrn_ena  out  1  pair valid to neuron.
- nrn_data  out  8  activation byte to neuron.
- nrn_weight  out  8  weight byte to neuron.
- busy  out  1  FSM not in IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_bit  out  1  captured frame result.

## Operation
- Buffers: two DEPTH x 8 arrays, each with a write count (a_cnt for activations, w_cnt for weights) of width clog2(DEPTH+1).
- Loads: write goes to index a_cnt or w_cnt of the selected buffer, then that count increments.
- ld_ready = ena & ~busy & (selected count < DEPTH). When a count reaches DEPTH, further writes to that buffer are refused.
- start is accepted only when in IDLE, ena=1, a_cnt==DEPTH and w_cnt==DEPTH. Otherwise it is ignored; no error flag.
- FSM states: IDLE -> CLR -> STREAM -> DRAIN -> DONE -> IDLE.
- CLR (1 cycle): nrn_rst=1.
- STREAM (DEPTH cycles): index k = 0..DEPTH-1, nrn_ena=1, nrn_data=act[k], nrn_weight=wgt[k].
- DRAIN (NRN_LAT cycles): nrn_ena=0. o_neuron is registered into res_bit at the edge ending the last DRAIN cycle.
- DONE (1 cycle): res_valid=1.
- On leaving DONE, a_cnt clears to 0, because activations are consumed by the frame. w_cnt is kept, so weights are reused until wclr.
- wclr: honoured only in IDLE; sets w_cnt=0. If wclr and a load to the weight buffer occur in the same cycle, wclr wins and the load is dropped (ld_ready is 0 that cycle for ld_sel=1).
- nrn_data/nrn_weight outside STREAM: hold their last values; the bench treats them as don't-care.

## Timing
- Reset values: ld_ready=0, busy=0, nrn_ena=0, nrn_data=0, nrn_weight=0, res_valid=0, res_bit=0, a_cnt=w_cnt=0, state=IDLE.
- nrn_rst=1 in every cycle where rst_n=1, so neuron and feeder reset together.
- Reset mid-frame aborts the frame: state goes to IDLE and both counts clear. Any in-flight result is lost, with no res_valid.
- Cycle numbering: start is accepted at edge E0; cycle n follows edge En-1 (cycle 1 follows E0).
- Frame schedule with the macro defined: CLR is cycle 1; STREAM is cycles 2..DEPTH+1; DRAIN is cycles DEPTH+2..DEPTH+1+NRN_LAT; DONE is cycle DEPTH+2+NRN_LAT.
- Default parameters: DONE (res_valid) is in cycle 12.
- busy is 1 from cycle 1 through DONE inclusive; IDLE is re-entered in the next cycle.
- A new start is accepted at the earliest in the cycle after DONE, and only once activations are reloaded.
- ena=0 in any state freezes state, index and drain counter; nrn_ena is forced 0. Schedule cycle counts extend by the stalled cycles.

## Configuration
- Macro: BNN_FEEDER_AUTOCLR_EN.
- Defined: the CLR state exists, and nrn_rst pulses once per frame as above.
- Not defined: there is no CLR state; IDLE goes straight to STREAM, so every later state moves one cycle earlier. DONE is in cycle DEPTH+1+NRN_LAT (11 at defaults). nrn_rst is driven only by rst_n.

## Test plan
- Load act[k]=0x00 and wgt[k]=0xFF for all 8 entries, then start (macro defined, neuron model attached) -> each XNOR is 0x00, accumulator 0 -> res_valid=1 in cycle 12, res_bit=1.
- Load act[k]=wgt[k]=0x5A, then start -> each XNOR is 0xFF (-1), accumulator -8 -> res_bit=0; nrn_ena high exactly in cycles 2–9.
- Issue start with a_cnt=7 -> ignored (busy stays 0). Write a 9th activation -> ld_ready=0 and the count stays 8.
- After a frame, reload activations only and start again -> the same weights are reused. Then wclr -> w_cnt=0 and start is refused.
- Drop ena=0 for 3 cycles during STREAM at k=4 -> nrn_ena=0 and k held while stalled. res_valid moves to cycle 15 and res_bit is unchanged versus an unstalled run.
- Assert rst_n=1 in DRAIN -> next cycle busy=0, a_cnt=w_cnt=0, no res_valid. With the macro undefined, rerun the first scenario -> res_valid in cycle 11.

Source files
------------

// File: rtl/bnn_neuron_feeder.sv
// bnn_neuron_feeder: buffers DEPTH activation/weight bytes and streams them into one binary neuron.
// Latency: res_valid DEPTH+NRN_LAT+2 cycles after start, or DEPTH+NRN_LAT+1 without BNN_FEEDER_AUTOCLR_EN.
// Backpressure: ld_ready drops while busy, when ena=0 or when the selected buffer is full; ena=0 freezes the frame.
module bnn_neuron_feeder #(
  parameter int DEPTH   = 8,
  parameter int NRN_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       ld_valid,
  input  logic       ld_sel,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       wclr,
  input  logic       start,
  input  logic       o_neuron,
  output logic       nrn_rst,
  output logic       nrn_ena,
  output logic [7:0] nrn_data,
  output logic [7:0] nrn_weight,
  output logic       busy,
  output logic       res_valid,
  output logic       res_bit
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(DEPTH);
  localparam int DW = (NRN_LAT > 1) ? $clog2(NRN_LAT) : 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NRN_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef BNN_FEEDER_AUTOCLR_EN
    S_CLR,
`endif
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] w_cnt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic [DW-1:0] dcnt;
  logic          nrn_ena_q;
  logic          idle;
  logic          ld_fire;
  logic          wclr_ok;
  logic          start_ok;

  logic [7:0] act_mem [DEPTH];
  logic [7:0] wgt_mem [DEPTH];

  assign idle     = (state == S_IDLE);
  assign busy     = ~idle;
  assign k_nxt    = k + KW'(1);
  assign wclr_ok  = ena & idle & wclr;
  // wclr beats a same-cycle weight load, so the weight side is refused outright.
  assign ld_ready = ~rst_n & ena & idle &
                    (ld_sel ? ((w_cnt < FULL) & ~wclr) : (a_cnt < FULL));
  assign ld_fire  = ld_valid & ld_ready;
  assign start_ok = ena & idle & start & (a_cnt == FULL) & (w_cnt == FULL);
  assign nrn_ena  = nrn_ena_q & ena;

`ifdef BNN_FEEDER_AUTOCLR_EN
  assign nrn_rst = rst_n | (state == S_CLR);
`else
  assign nrn_rst = rst_n;
`endif

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (ld_sel) wgt_mem[w_cnt[KW-1:0]] <= ld_data;
      else        act_mem[a_cnt[KW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= S_IDLE;
      a_cnt      <= '0;
      w_cnt      <= '0;
      k          <= '0;
      dcnt       <= '0;
      nrn_ena_q  <= 1'b0;
      nrn_data   <= '0;
      nrn_weight <= '0;
      res_valid  <= 1'b0;
      res_bit    <= 1'b0;
    end else if (ena) begin
      if (ld_fire && !ld_sel) a_cnt <= a_cnt + CW'(1);
      if (wclr_ok)                 w_cnt <= '0;
      else if (ld_fire && ld_sel)  w_cnt <= w_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (start_ok) begin
`ifdef BNN_FEEDER_AUTOCLR_EN
            state      <= S_CLR;
`else
            state      <= S_STREAM;
            k          <= '0;
            nrn_ena_q  <= 1'b1;
            nrn_data   <= act_mem[0];
            nrn_weight <= wgt_mem[0];
`endif
          end
        end
`ifdef BNN_FEEDER_AUTOCLR_EN
        S_CLR: begin
          state      <= S_STREAM;
          k          <= '0;
          nrn_ena_q  <= 1'b1;
          nrn_data   <= act_mem[0];
          nrn_weight <= wgt_mem[0];
        end
`endif
        S_STREAM: begin
          if (k == K_LAST) begin
            state     <= S_DRAIN;
            dcnt      <= '0;
            nrn_ena_q <= 1'b0;
          end else begin
            k          <= k_nxt;
            nrn_data   <= act_mem[k_nxt];
            nrn_weight <= wgt_mem[k_nxt];
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            state     <= S_DONE;
            res_bit   <= o_neuron;
            res_valid <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE: begin
          // Activations are consumed by the frame; weights stay until wclr.
          state     <= S_IDLE;
          res_valid <= 1'b0;
          a_cnt     <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_neuron_feeder.sv
// Bench for bnn_neuron_feeder with a behavioural XNOR/popcount-style binary neuron attached.
module tb_bnn_neuron_feeder;
  localparam int DEPTH   = 8;
  localparam int NRN_LAT = 2;
`ifdef BNN_FEEDER_AUTOCLR_EN
  localparam int SF = 2;
`else
  localparam int SF = 1;
`endif
  localparam int DONE_CYC = SF + DEPTH + NRN_LAT;

  logic       clk = 1'b0;
  logic       rst_n, ena, ld_valid, ld_sel, wclr, start, o_neuron;
  logic [7:0] ld_data;
  logic       ld_ready, nrn_rst, nrn_ena, busy, res_valid, res_bit;
  logic [7:0] nrn_data, nrn_weight;

  bnn_neuron_feeder #(.DEPTH(DEPTH), .NRN_LAT(NRN_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_data(ld_data), .ld_ready(ld_ready), .wclr(wclr), .start(start),
    .o_neuron(o_neuron), .nrn_rst(nrn_rst), .nrn_ena(nrn_ena), .nrn_data(nrn_data),
    .nrn_weight(nrn_weight), .busy(busy), .res_valid(res_valid), .res_bit(res_bit)
  );

  always #5 clk = ~clk;

  // Neuron model: signed XNOR accumulate, registered sign (1 = non-negative).
  logic signed [15:0] acc;
  logic               model_clr;
  logic [7:0]         xn;
  assign xn = ~(nrn_data ^ nrn_weight);
  always @(posedge clk) begin
    if (nrn_rst || model_clr) acc <= '0;
    else if (nrn_ena)         acc <= acc + {{8{xn[7]}}, xn};
    o_neuron <= ~acc[15];
  end

  typedef struct packed {
    logic [63:0] act;
    logic [63:0] wgt;
    logic        exp;
  } vec_t;
  typedef struct {
    logic res;
    int   cyc;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, want);
  endtask

  task automatic load(input logic sel, input logic [63:0] v, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ld_valid = 1'b1; ld_sel = sel; ld_data = v[8*i +: 8];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; model_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; model_clr = 1'b0;
  endtask

  task automatic run_frame(input logic [63:0] av, input logic [63:0] wv, input logic exp_bit,
                           input int stall_len, input string nm);
    exp_t e;
    int first_ena, last_ena, n_ena, bad_pair, bad_busy, n_res, done_cyc, exp_done, stall_at;
    exp_done = DONE_CYC + stall_len;
    stall_at = SF + 4;
    e.res = exp_bit; e.cyc = exp_done;
    sb.push_back(e);
    first_ena = -1; last_ena = -1; n_ena = 0; bad_pair = 0; bad_busy = 0; n_res = 0; done_cyc = -1;
    pulse_start();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      ena = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (busy !== (cyc <= exp_done)) bad_busy++;
      if (nrn_ena === 1'b1) begin
        if (first_ena < 0) first_ena = cyc;
        last_ena = cyc;
        if (n_ena < DEPTH && (nrn_data !== av[8*n_ena +: 8] || nrn_weight !== wv[8*n_ena +: 8]))
          bad_pair++;
        n_ena++;
      end
      if (res_valid === 1'b1) begin
        n_res++;
        if (sb.size() == 0) begin
          chk({nm, "_unexpected_res"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({nm, "_res_cyc"}, cyc, e.cyc);
          chk({nm, "_res_bit"}, {31'b0, res_bit}, {31'b0, e.res});
          done_cyc = cyc;
        end
      end
      if (done_cyc > 0 && cyc > done_cyc) break;
      @(posedge clk); #1;
    end
    ena = 1'b1;
    if (sb.size() != 0) begin
      chk({nm, "_timeout_pending"}, sb.size(), 0);
      sb.delete();
    end
    chk({nm, "_ena_first"}, first_ena, SF);
    chk({nm, "_ena_last"}, last_ena, SF + DEPTH - 1 + stall_len);
    chk({nm, "_ena_count"}, n_ena, DEPTH);
    chk({nm, "_pair_errs"}, bad_pair, 0);
    chk({nm, "_busy_errs"}, bad_busy, 0);
    chk({nm, "_res_count"}, n_res, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_rv;
    tbl[0] = '{act: 64'h0,                   wgt: 64'hFFFF_FFFF_FFFF_FFFF, exp: 1'b1}; // sum 0
    tbl[1] = '{act: 64'h5A5A_5A5A_5A5A_5A5A, wgt: 64'h5A5A_5A5A_5A5A_5A5A, exp: 1'b0}; // -8
    tbl[2] = '{act: 64'h8080_8080_8080_8080, wgt: 64'h0,                   exp: 1'b1}; // +1016
    tbl[3] = '{act: 64'h0,                   wgt: 64'h0101_0101_FEFE_FEFE, exp: 1'b0}; // -4
    tbl[4] = '{act: 64'h0,                   wgt: 64'hFFFF_FFFF_FF01_FEFE, exp: 1'b1}; // 0
    tbl[5] = '{act: 64'h0,                   wgt: 64'hFFFF_FFFF_FFFF_01FE, exp: 1'b0}; // -1
    tbl[6] = '{act: 64'h0,                   wgt: 64'hFEFE_FEFE_FEFE_FEFE, exp: 1'b1}; // +8

    rst_n = 1'b1; ena = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0;
    wclr = 1'b0; start = 1'b0; model_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nrn_ena", nrn_ena, 0);
    chk("rst_nrn_data", nrn_data, 0);
    chk("rst_nrn_weight", nrn_weight, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_bit", res_bit, 0);
    chk("rst_nrn_rst", nrn_rst, 1);
    chk("rst_a_cnt", dut.a_cnt, 0);
    chk("rst_w_cnt", dut.w_cnt, 0);
    rst_n = 1'b0; #1;
    chk("idle_nrn_rst", nrn_rst, 0);
    chk("idle_ld_ready", ld_ready, 1);

    // Short activation buffer: start must be ignored, then the buffer saturates at DEPTH.
    load(1'b1, tbl[0].wgt, 0, DEPTH);
    load(1'b0, tbl[0].act, 0, DEPTH - 1);
    pulse_start();
    chk("short_start_busy", busy, 0);
    load(1'b0, tbl[0].act, DEPTH - 1, DEPTH);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'h33; #1;
    chk("act_full_ready", ld_ready, 0);
    ld_sel = 1'b1; #1;
    chk("wgt_full_ready", ld_ready, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    chk("act_cnt_sat", dut.a_cnt, DEPTH);
    chk("wgt_cnt_sat", dut.w_cnt, DEPTH);

    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        wclr = 1'b1; @(posedge clk); #1; wclr = 1'b0;
        load(1'b1, tbl[i].wgt, 0, DEPTH);
        load(1'b0, tbl[i].act, 0, DEPTH);
      end
      run_frame(tbl[i].act, tbl[i].wgt, tbl[i].exp, 0, $sformatf("v%0d", i));
    end
    chk("post_frame_a_cnt", dut.a_cnt, 0);
    chk("post_frame_w_cnt", dut.w_cnt, DEPTH);

    // Weights reused: act 0xFF against 0xFE weights gives -2 per pair.
    load(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, DEPTH);
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, tbl[6].wgt, 1'b0, 0, "reuse");

    // wclr collides with a weight load: clear wins, load refused.
    ld_valid = 1'b1; ld_sel = 1'b1; ld_data = 8'h77; wclr = 1'b1; #1;
    chk("wclr_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0; wclr = 1'b0;
    chk("wclr_w_cnt", dut.w_cnt, 0);
    load(1'b0, 64'h0, 0, DEPTH);
    pulse_start();
    chk("nowgt_start_busy", busy, 0);
    chk("nowgt_a_cnt_kept", dut.a_cnt, DEPTH);

    // Three-cycle ena stall at k=4; act 0 vs weight 0x5A gives 0xA5 (-91) per pair.
    load(1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 0, DEPTH);
    run_frame(64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 3, "stall");

    // Reset while in DRAIN: frame aborted, no result strobe.
    load(1'b0, 64'h0, 0, DEPTH);
    pulse_start();
    repeat (SF + DEPTH - 1) @(posedge clk);
    #1;
    chk("drain_busy", busy, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_a_cnt", dut.a_cnt, 0);
    chk("abort_w_cnt", dut.w_cnt, 0);
    n_rv = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid === 1'b1) n_rv++;
      @(posedge clk); #1;
    end
    chk("abort_res_valid", n_rv, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
